// File: rtl/pipe_adder_pkg.sv
// ============================================================================
// pipe_adder_pkg : shared types and helpers for the pipelined adder/subtractor
// Optional feature macro: PIPE_ADDER_OVF_EN (adds MSB bits to the stage record)
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_mode_e;

    // Control half of a stage record; the partial sum and the remaining
    // operands travel beside it as WIDTH-bit vectors sized by the instance.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PIPE_ADDER_OVF_EN
        logic a_msb;
        logic b_msb;
`endif
    } stage_ctl_t;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk_stage.sv
// ============================================================================
// adder_chunk_stage : CHUNK-bit ripple add of chunk IDX plus its stage register
// Optional feature macro: PIPE_ADDER_OVF_EN (via the stage record type)
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_chunk_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  stage_ctl_t       ctl_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output stage_ctl_t       ctl_o,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   chunk_add;
    stage_ctl_t       ctl_d, ctl_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;

    // Consumed operand chunks are zeroed so their flops fold away downstream.
    always_comb begin
        chunk_add = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, ctl_i.carry};
        ctl_d       = ctl_i;
        ctl_d.carry = chunk_add[CHUNK];
        sum_d       = sum_i;
        sum_d[LO +: CHUNK] = chunk_add[CHUNK-1:0];
        a_d         = a_i;
        a_d[LO +: CHUNK]   = '0;
        b_d         = b_i;
        b_d[LO +: CHUNK]   = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '0;
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (en_i) begin
            ctl_q <= ctl_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign ctl_o = ctl_q;
    assign sum_o = sum_q;
    assign a_o   = a_q;
    assign b_o   = b_q;

endmodule

`default_nettype wire

// File: rtl/pipe_adder.sv
// ============================================================================
// pipe_adder : pipelined ripple-carry adder/subtractor with valid/ready flow
// Optional feature macro: PIPE_ADDER_OVF_EN (adds signed-overflow output ovf)
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    generate
        if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipe_adder: illegal WIDTH/STAGES combination");
        end
    endgenerate

    op_mode_e         mode;
    logic             stall;
    logic             en;
    stage_ctl_t       head_ctl;
    logic [WIDTH-1:0] b_eff;

    stage_ctl_t       st_ctl [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];

    assign mode     = op_mode_e'(sub);
    assign b_eff    = (mode == SUB) ? ~b : b;
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    always_comb begin
        head_ctl       = '0;
        head_ctl.valid = in_valid;
        head_ctl.carry = (mode == SUB) ? 1'b1 : cin;
`ifdef PIPE_ADDER_OVF_EN
        head_ctl.a_msb = a[WIDTH-1];
        head_ctl.b_msb = b_eff[WIDTH-1];
`endif
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            stage_ctl_t       ctl_in;
            logic [WIDTH-1:0] sum_in;
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;

            if (k == 0) begin : g_head
                assign ctl_in = head_ctl;
                assign sum_in = '0;
                assign a_in   = a;
                assign b_in   = b_eff;
            end else begin : g_link
                assign ctl_in = st_ctl[k-1];
                assign sum_in = st_sum[k-1];
                assign a_in   = st_a[k-1];
                assign b_in   = st_b[k-1];
            end

            adder_chunk_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (k)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (en),
                .ctl_i (ctl_in),
                .sum_i (sum_in),
                .a_i   (a_in),
                .b_i   (b_in),
                .ctl_o (st_ctl[k]),
                .sum_o (st_sum[k]),
                .a_o   (st_a[k]),
                .b_o   (st_b[k])
            );
        end
    endgenerate

    assign out_valid = st_ctl[STAGES-1].valid;
    assign sum       = st_sum[STAGES-1];
    assign cout      = st_ctl[STAGES-1].carry;

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = (st_ctl[STAGES-1].a_msb == st_ctl[STAGES-1].b_msb)
               & (sum[WIDTH-1] != st_ctl[STAGES-1].a_msb);
`endif

    // Operand remnants leaving the last stage are all-zero by construction.
    logic unused_tail;
    assign unused_tail = ^{st_a[STAGES-1], st_b[STAGES-1]};

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ============================================================================
// tb_pipe_adder : randomized scoreboard bench for pipe_adder (WIDTH=32, STAGES=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               id;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   retired = 0;
    int   nid = 0;
    int   cyc = 0;
    int   stall_from = 32'h7fff_ffff;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain unsigned arithmetic for sum/cout, signed range for ovf.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, mb, input logic mcin, msub);
        exp_t        e;
        logic [32:0] t;
        longint      s;
        if (msub) begin
            t[31:0] = ma - mb;
            t[32]   = (ma >= mb);
            s = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            t = {1'b0, ma} + {1'b0, mb} + {32'd0, mcin};
            s = longint'($signed(ma)) + longint'($signed(mb)) + (mcin ? 64'sd1 : 64'sd0);
        end
        e.sum  = t[31:0];
        e.cout = t[32];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.id   = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= stall_from && cyc < stall_from + 3) out_ready = 1'b0;
            else if (rand_rdy)                              out_ready = ($urandom_range(0, 3) != 0);
            else                                            out_ready = 1'b1;
        end
    end

    // Input side: the expected response is queued when a beat is accepted.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e    = model(a, b, cin, sub);
            e.id = nid;
            nid  = nid + 1;
            exp_q.push_back(e);
        end
    end

    // Output side: compare on retirement, check hold behaviour under stall.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || sum !== prev_sum || cout !== prev_cout) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b sum=%h cout=%b, expected valid=1 sum=%h cout=%b",
                             out_valid, sum, cout, prev_sum, prev_cout);
                end
            end
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, expected %b (out_valid=%b out_ready=%b)",
                         in_ready, !(out_valid && !out_ready), out_valid, out_ready);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum=%h cout=%b, expected no result", sum, cout);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    retired++;
                    checks++;
                    if (sum !== e.sum || cout !== e.cout) begin
                        errors++;
                        $display("FAIL result#%0d: got sum=%h cout=%b, expected sum=%h cout=%b",
                                 e.id, sum, cout, e.sum, e.cout);
                    end
`ifdef PIPE_ADDER_OVF_EN
                    checks++;
                    if (ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL ovf#%0d: got %b, expected %b", e.id, ovf, e.ovf);
                    end
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] ta, tb, input logic tcin, tsub);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        cin = tcin;
        sub = tsub;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    initial begin
        int n;
        int r0;
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        cin = 1'b1;
        sub = 1'b0;

        // Reset held with a valid beat pending
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_sum", sum, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(6);

        // Carry ripple through every chunk, with exact latency
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        check("ripple_latency", n, STAGES - 1);
        check("ripple_sum", sum, 32'h0000_0000);
        check("ripple_cout", {31'd0, cout}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Subtraction, borrow and no-borrow, cin ignored
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'd7, 32'd5, 1'b0, 1'b1);
        // Signed overflow corners
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        drain();

        // Backpressure mid-stream
        r0 = retired;
        stall_from = cyc + 4;
        for (int i = 0; i < 8; i++) send(i, i, 1'b0, 1'b0);
        drain();
        stall_from = 32'h7fff_ffff;
        check("bp_count", retired - r0, 8);

        // Random traffic with random backpressure and bubbles
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        drain();

        // Reset while beats are in flight
        send(32'd10, 32'd20, 1'b0, 1'b0);
        send(32'd30, 32'd40, 1'b0, 1'b0);
        send(32'd50, 32'd60, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_sum", sum, 32'd0);
        check("midreset_cout", {31'd0, cout}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // Pipeline is usable again after reset
        r0 = retired;
        send(32'd3, 32'd4, 1'b1, 1'b0);
        drain();
        check("post_reset_count", retired - r0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
